demux_dest_n: RTL



---
 rtl/demux_dest_n.sv | 107 ++++++++++
 1 files changed

// File: rtl/demux_dest_n.sv
// demux_dest_n: N-way destination demultiplexer with one small FIFO per destination.
// Each input word is steered by its destination field data_in[DEST_LSB +: DW]
// into that destination's FIFO; every FIFO head is shown on its own output slice.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   data_in    input word (BW bits), destination field at DEST_LSB
//   valid_in   data_in is valid
//   ready_in   combinational: the FIFO addressed by data_in has room
//   data_out   NUM_DEST slices of BW bits, slice i = head of FIFO i (0 when empty)
//   valid_out  bit i set when FIFO i is non-empty
//   ready_out  bit i: consumer i takes the head word
//   cnt_out    per-destination accepted-word counters, CNT_W bits each
//              (present only when DEMUX_DEST_STATS_EN is defined)
//
// Optional feature macro: DEMUX_DEST_STATS_EN
module demux_dest_n #(
  parameter int unsigned BW       = 6,
  parameter int unsigned NUM_DEST = 2,
  parameter int unsigned DEST_LSB = 4,
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned CNT_W    = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [BW-1:0]                data_in,
  input  logic                         valid_in,
  output logic                         ready_in,
  output logic [NUM_DEST*BW-1:0]       data_out,
  output logic [NUM_DEST-1:0]          valid_out,
  input  logic [NUM_DEST-1:0]          ready_out
`ifdef DEMUX_DEST_STATS_EN
  ,
  output logic [NUM_DEST*CNT_W-1:0]    cnt_out
`endif
);

  localparam int unsigned DW = $clog2(NUM_DEST);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  // Parameter sanity checks, evaluated at elaboration only
  if ((NUM_DEST < 2) || ((NUM_DEST & (NUM_DEST - 1)) != 0) ||
      (DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) ||
      (DEST_LSB + DW > BW) || (CNT_W < 1)) begin : g_param_err
    $error("demux_dest_n: illegal parameter combination");
  end

  logic [DW-1:0]       dest;
  logic [NUM_DEST-1:0] full;
  logic                push_acc;

  assign dest = data_in[DEST_LSB +: DW];

  // No pass-through: a full FIFO refuses even when it is popped this cycle
  assign ready_in = !reset && !full[dest];
  assign push_acc = valid_in && ready_in;

  for (genvar i = 0; i < NUM_DEST; i++) begin : g_dest
    logic [BW-1:0] mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;

    assign push = push_acc && (dest == DW'(i));
    assign pop  = valid_out[i] && ready_out[i];

    assign full[i]      = (count == CW'(DEPTH));
    assign valid_out[i] = (count != '0);
    assign data_out[i*BW +: BW] = valid_out[i] ? mem[rd_ptr] : '0;

    // Pointer/count state; pointers wrap naturally since DEPTH is a power of 2
    always_ff @(posedge clk) begin
      if (reset) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        if (push && !pop)      count <= count + CW'(1);
        else if (!push && pop) count <= count - CW'(1);
      end
    end

    // Storage needs no reset: empty FIFOs are masked on data_out
    always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= data_in;
    end

`ifdef DEMUX_DEST_STATS_EN
    logic [CNT_W-1:0] cnt;

    // Accepted-push counter, wraps modulo 2^CNT_W
    always_ff @(posedge clk) begin
      if (reset)     cnt <= '0;
      else if (push) cnt <= cnt + CNT_W'(1);
    end

    assign cnt_out[i*CNT_W +: CNT_W] = cnt;
`endif
  end

endmodule
